// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and helpers for the byte-wide RAM sequencer
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // Number of single-byte RAM cycles a request of this length needs
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // True when the access cannot be issued: bad alignment or the reserved length code
    function automatic logic misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
        logic bad;
        case (len)
            LEN_B:   bad = 1'b0;
            LEN_H:   bad = addr_lo[0];
            LEN_W:   bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, bit 0 = fetch port, bit 1 = data port
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    // 1 when the data port was granted most recently; reset favours D on the first tie
    logic last_d;

    // One-hot grant; on a tie the port that did not win last time goes first
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_d ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only when a grant is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (grant_en) begin
            last_d <= grant[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the byte-wide RAM between fetch and load/store ports
module ram_arbiter
    import ram_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_len,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_exception
);

    state_t      state;
    logic        sel_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        rw_q;
    logic [1:0]  len_q;
    logic        err_q;
    logic [1:0]  cnt;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        grant_en;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [1:0]  g_len;
    logic        g_rw;
    logic        last_byte;
    logic [4:0]  byte_sel;

    assign req      = {d_req, i_req};
    assign grant_en = (state == IDLE) && (|req);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    // Fields of the winning port; the fetch port is always a word read
    always_comb begin
        g_addr  = grant[1] ? d_addr  : i_addr;
        g_wdata = grant[1] ? d_wdata : 32'h0;
        g_len   = grant[1] ? d_len   : LEN_W;
        g_rw    = grant[1] & d_rw;
    end

    assign last_byte = ({1'b0, cnt} == (len_to_bytes(len_q) - 3'd1));
    assign byte_sel  = {cnt, 3'b000};

    // Sequencer: grant and latch, walk bytes little-endian, then one response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_d   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            rw_q    <= 1'b0;
            len_q   <= LEN_B;
            err_q   <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        sel_d   <= grant[1];
                        addr_q  <= g_addr;
                        wdata_q <= g_wdata;
                        rw_q    <= g_rw;
                        len_q   <= g_len;
                        rdata_q <= 32'h0;
                        cnt     <= 2'd0;
                        if (misaligned(g_len, g_addr[1:0])) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (mem_exception) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        if (!rw_q) begin
                            rdata_q[byte_sel +: 8] <= mem_rdata;
                        end
                        if (last_byte) begin
                            state <= RESP;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port responses exist only in RESP; the RAM bus is quiet outside XFER
    always_comb begin
        i_ack     = (state == RESP) && !sel_d;
        d_ack     = (state == RESP) && sel_d;
        i_rdata   = i_ack ? rdata_q : 32'h0;
        i_err     = i_ack & err_q;
        d_rdata   = d_ack ? rdata_q : 32'h0;
        d_err     = d_ack & err_q;
        mem_addr  = 32'h0;
        mem_wdata = 8'h0;
        mem_rw    = 1'b0;
        if (state == XFER) begin
            mem_addr = addr_q + {30'h0, cnt};
            mem_rw   = rw_q & ~mem_exception;
            if (rw_q) begin
                mem_wdata = wdata_q[byte_sel +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

    localparam int RAM_WIDTH = 10;
    localparam int RAM_SIZE  = 1 << (RAM_WIDTH + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_len;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_exception;

    logic [7:0]  ram [0:RAM_SIZE-1] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:RAM_SIZE-1];
    logic        tb_we = 1'b0;
    logic [RAM_WIDTH:0] tb_wa = '0;
    logic [7:0]  tb_wd = 8'h0;

    int total = 0;
    int bad   = 0;

    ram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_ack         (i_ack),
        .i_rdata       (i_rdata),
        .i_err         (i_err),
        .d_req         (d_req),
        .d_rw          (d_rw),
        .d_len         (d_len),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_ack         (d_ack),
        .d_rdata       (d_rdata),
        .d_err         (d_err),
        .mem_rw        (mem_rw),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_exception (mem_exception)
    );

    always #5 clk = ~clk;

    assign mem_exception = |mem_addr[31:RAM_WIDTH+1];
    assign mem_rdata     = ram[mem_addr[RAM_WIDTH:0]];

    always @(posedge clk) begin
        if (tb_we) begin
            ram[tb_wa] <= tb_wd;
        end else if (mem_rw && !mem_exception) begin
            ram[mem_addr[RAM_WIDTH:0]] <= mem_wdata;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference: bytes in little-endian order, abort at the first out-of-range address
    task automatic model(input bit pd, input bit rw_in, input logic [1:0] len_in,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output bit er, output int lat, output int nwr);
        int nb;
        bit rw;
        logic [1:0] len;
        logic [31:0] a;
        rw  = pd ? rw_in : 1'b0;
        len = pd ? len_in : 2'b10;
        nb  = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        rd  = 32'h0;
        er  = 1'b0;
        nwr = 0;
        lat = nb + 1;
        if (len == 2'b11 || (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0)) begin
            er  = 1'b1;
            lat = 1;
        end else begin
            for (int n = 0; n < nb; n++) begin
                a = addr + n;
                if ((a >> (RAM_WIDTH + 1)) != 0) begin
                    er  = 1'b1;
                    lat = n + 2;
                    break;
                end
                if (rw) begin
                    ref_mem[a[RAM_WIDTH:0]] = wdata[8*n +: 8];
                    nwr++;
                end else begin
                    rd = rd | (32'(ref_mem[a[RAM_WIDTH:0]]) << (8 * n));
                end
            end
        end
    endtask

    task automatic run_req(input bit pd, input bit rw, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata, input string nm,
                           input bit use_exp, input logic [31:0] x_rd, input bit x_er,
                           input int x_lat, input int x_wr);
        logic [31:0] m_rd;
        bit m_er;
        int m_lat;
        int m_wr;
        int e;
        bit got;
        int wr;
        bit addr_ok;
        bit stray;
        logic [31:0] g_rd;
        logic g_er;
        model(pd, rw, len, addr, wdata, m_rd, m_er, m_lat, m_wr);
        if (!use_exp) begin
            x_rd  = m_rd;
            x_er  = m_er;
            x_lat = m_lat;
            x_wr  = m_wr;
        end
        e = 0; got = 0; wr = 0; addr_ok = 1; stray = 0; g_rd = 32'h0; g_er = 1'b0;
        @(negedge clk);
        if (pd) begin
            d_req = 1'b1; d_rw = rw; d_len = len; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        while (!got && e < 20) begin
            @(posedge clk);
            @(negedge clk);
            e++;
            if (pd ? i_ack : d_ack) stray = 1;
            if (!i_ack && (i_rdata != 0 || i_err)) stray = 1;
            if (!d_ack && (d_rdata != 0 || d_err)) stray = 1;
            if (pd ? d_ack : i_ack) begin
                got  = 1;
                g_rd = pd ? d_rdata : i_rdata;
                g_er = pd ? d_err : i_err;
                if (mem_rw) stray = 1;
            end else begin
                if (mem_addr !== addr + 32'(e - 1)) addr_ok = 0;
                if (mem_rw) wr++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check({nm, " ack_seen"}, 32'(got), 32'd1);
        check({nm, " latency"}, 32'(e), 32'(x_lat));
        check({nm, " rdata"}, g_rd, x_rd);
        check({nm, " err"}, 32'(g_er), 32'(x_er));
        check({nm, " writes"}, 32'(wr), 32'(x_wr));
        check({nm, " addr_seq_ok"}, 32'(addr_ok), 32'd1);
        check({nm, " no_stray"}, 32'(stray), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " i_ack"}, 32'(i_ack), 32'd0);
        check({nm, " i_rdata"}, i_rdata, 32'd0);
        check({nm, " i_err"}, 32'(i_err), 32'd0);
        check({nm, " d_ack"}, 32'(d_ack), 32'd0);
        check({nm, " d_rdata"}, d_rdata, 32'd0);
        check({nm, " d_err"}, 32'(d_err), 32'd0);
        check({nm, " mem_rw"}, 32'(mem_rw), 32'd0);
        check({nm, " mem_addr"}, mem_addr, 32'd0);
        check({nm, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    typedef struct {
        bit          pd;
        bit          rw;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] x_rd;
        bit          x_er;
        int          x_lat;
        int          x_wr;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic [RAM_WIDTH:0] pre_a[5] = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h7FF};
    logic [7:0]         pre_d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h9C};

    initial begin
        bit seen_i;
        int nacks;
        bit both;
        bit order[4];
        logic [31:0] adata[4];
        int diffs;
        bit pd;
        bit rw;
        logic [1:0] len;
        logic [31:0] addr;

        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_rw = 1'b0; d_len = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
        for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_wa = pre_a[i]; tb_wd = pre_d[i];
            ref_mem[pre_a[i]] = pre_d[i];
        end
        @(negedge clk);
        tb_we = 1'b0;
        check_all_zero("reset");

        // Contention right after reset: D must win first, then strict alternation
        @(negedge clk);
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_rw = 1'b0; d_len = 2'b00; d_addr = 32'h21;
        nacks = 0; both = 0;
        for (int c = 0; c < 60 && nacks < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (i_ack && d_ack) both = 1;
            if (i_ack || d_ack) begin
                order[nacks] = d_ack;
                adata[nacks] = d_ack ? d_rdata : i_rdata;
                nacks++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("contention acks", 32'(nacks), 32'd4);
        check("contention both_acks", 32'(both), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("contention grant%0d_is_d", k), 32'(order[k]), 32'((k % 2) == 0));
            check($sformatf("contention data%0d", k), adata[k], (k % 2 == 0) ? 32'h0 : 32'h44332211);
        end

        // Directed vector table; expected values worked out by hand from the preload
        vecs.push_back('{0, 0, 2'b10, 32'h10,  32'h0,        32'h44332211, 0, 5, 0, "i_word_0x10"});
        vecs.push_back('{1, 1, 2'b01, 32'h20,  32'hA5A5BEEF, 32'h0,        0, 3, 2, "d_half_st_0x20"});
        vecs.push_back('{1, 0, 2'b00, 32'h21,  32'h0,        32'h000000BE, 0, 2, 0, "d_byte_ld_0x21"});
        vecs.push_back('{1, 0, 2'b00, 32'h22,  32'h0,        32'h0,        0, 2, 0, "d_byte_ld_0x22"});
        vecs.push_back('{1, 0, 2'b10, 32'h22,  32'h0,        32'h0,        1, 1, 0, "d_word_mis_0x22"});
        vecs.push_back('{1, 1, 2'b11, 32'h0,   32'hFFFFFFFF, 32'h0,        1, 1, 0, "d_len11_0x0"});
        vecs.push_back('{1, 0, 2'b01, 32'h21,  32'h0,        32'h0,        1, 1, 0, "d_half_mis_0x21"});
        vecs.push_back('{1, 1, 2'b10, 32'h800, 32'h12345678, 32'h0,        1, 2, 0, "d_word_st_0x800"});
        vecs.push_back('{1, 0, 2'b01, 32'h7FF, 32'h0,        32'h0,        1, 1, 0, "d_half_mis_0x7ff"});
        vecs.push_back('{1, 0, 2'b00, 32'h7FF, 32'h0,        32'h0000009C, 0, 2, 0, "d_byte_ld_0x7ff"});
        vecs.push_back('{1, 0, 2'b10, 32'h7FC, 32'h0,        32'h9C000000, 0, 5, 0, "d_word_ld_0x7fc"});
        vecs.push_back('{1, 1, 2'b01, 32'h7FE, 32'h00003C00, 32'h0,        0, 3, 2, "d_half_st_0x7fe"});
        vecs.push_back('{1, 0, 2'b10, 32'h20,  32'h0,        32'h0000BEEF, 0, 5, 0, "d_word_ld_0x20"});
        vecs.push_back('{0, 0, 2'b10, 32'h12,  32'h0,        32'h0,        1, 1, 0, "i_word_mis_0x12"});
        vecs.push_back('{1, 1, 2'b10, 32'h30,  32'hCAFEF00D, 32'h0,        0, 5, 4, "d_word_st_0x30"});
        vecs.push_back('{1, 0, 2'b10, 32'h30,  32'h0,        32'hCAFEF00D, 0, 5, 0, "d_word_ld_0x30"});
        vecs.push_back('{0, 0, 2'b10, 32'h1000, 32'h0,       32'h0,        1, 2, 0, "i_word_exc"});
        foreach (vecs[v]) begin
            run_req(vecs[v].pd, vecs[v].rw, vecs[v].len, vecs[v].addr, vecs[v].wdata,
                    vecs[v].name, 1'b1, vecs[v].x_rd, vecs[v].x_er, vecs[v].x_lat, vecs[v].x_wr);
        end

        // Reset during the third byte of a word fetch: abort with no ack, then recover
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst byte2 mem_addr", mem_addr, 32'h12);
        rst = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        seen_i = 0;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack) seen_i = 1;
        end
        check("midrst no_replay_ack", 32'(seen_i), 32'd0);
        run_req(0, 0, 2'b10, 32'h10, 32'h0, "post_rst_fetch", 1'b1, 32'h44332211, 0, 5, 0);

        // Random requests checked against the reference model
        for (int r = 0; r < 60; r++) begin
            pd  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            len = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: addr = 32'($urandom_range(0, 63));
                1: addr = 32'($urandom_range(0, RAM_SIZE - 1));
                2: addr = 32'(RAM_SIZE - 4 + $urandom_range(0, 7));
                default: addr = $urandom;
            endcase
            run_req(pd, rw, len, addr, $urandom, $sformatf("rand%0d", r), 1'b0, 32'h0, 0, 0, 0);
        end

        diffs = 0;
        for (int i = 0; i < RAM_SIZE; i++) begin
            if (ram[i] !== ref_mem[i]) diffs++;
        end
        check("ram_contents_diffs", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencing controller and two-port arbiter in front of the byte-wide data RAM. It shares the RAM between the instruction-fetch port (I) and the load/store port (D). Each accepted request is broken into 1, 2 or 4 single-byte RAM cycles in little-endian order. The block also performs alignment checking and turns RAM range exceptions into a per-request error response.

## Interface

- RAM_WIDTH, 10, RAM address width; passed through to the RAM, which raises its exception for any address with a nonzero bit in [31:RAM_WIDTH+1].

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  1  instruction fetch request; always a word read
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  32  fetched word, valid only while i_ack=1, else 0
- i_err  out  1  error flag, valid only while i_ack=1
- d_req  in  1  data request
- d_rw  in  1  1=write, 0=read
- d_len  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; byte i at [8i+7:8i]
- d_ack / d_rdata / d_err  out  1/32/1  as for the I port
- mem_rw  out  1  RAM write strobe
- mem_addr  out  32  RAM byte address
- mem_wdata  out  8  RAM write byte
- mem_rdata  in  8  RAM read byte, combinational from mem_addr
- mem_exception  in  1  RAM out-of-range flag, combinational from mem_addr

## Operation

- FSM states are IDLE, XFER and RESP.
- **IDLE:** sample i_req/d_req and arbitrate.
  - One request pending: grant it.
  - Both pending: round-robin, granting the port not granted last.
  - Grant and request fields (addr, rw, len, wdata) are latched.
- **Checks at grant time:**
  - d_len=11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - On a check error, go directly to RESP with err=1. Zero RAM cycles are issued.
- **XFER:**
  - Byte counter n runs from 0 to N-1, where N = 1/2/4 from len.
  - mem_addr = latched_addr + n.
  - Write: mem_rw=1, mem_wdata = wdata[8n+7:8n].
  - Read: mem_rdata is captured into rdata[8n+7:8n] at the clock edge.
  - If mem_exception=1 in any XFER cycle:
    - Set err.
    - Drive mem_rw=0 for that cycle.
    - Go to RESP immediately. No further bytes are issued.
  - Bytes already written stay written.
- **RESP:**
  - The granted port's ack=1 for exactly one cycle, with rdata and err.
  - Read data is zero-extended; unread upper bytes are 0.
  - Sign extension is the CPU's job.
  - Next state is IDLE.
- **Outputs outside XFER:** mem_rw=0, mem_addr=0, mem_wdata=0.
- **Requester protocol:**
  - Hold req and all fields stable until ack.
  - Requests are level-sensitive.
  - A requester still asserting req after ack is treated as a new request in the next IDLE.
- If req drops mid-transfer, the transfer still completes and acks.

## Timing

- **Reset:**
  - state=IDLE.
  - All outputs are 0: i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_rw, mem_addr, mem_wdata.
  - Last-grant pointer = I, so D wins the first tie after reset.
- **Latency:** request accepted at edge k (IDLE) → XFER for cycles k+1..k+N → ack high in cycle k+N+1.
  - Byte: ack 2 cycles after accept.
  - Half: ack 3 cycles after accept.
  - Word: ack 5 cycles after accept.
  - Check error: ack at k+1.
  - Exception at byte n: ack at cycle k+n+2.
- **Throughput:** the arbiter is idle for 1 cycle between back-to-back requests, because RESP→IDLE→grant.
- **Reset mid-operation:** abort immediately. No ack is issued, and the aborted request is not replayed.
- Only one ack is ever high per cycle, and only for the granted port.
- The arbiter pointer updates only on a grant, never on idle cycles.

## Structure

- **Package ram_ctrl_pkg:**
  - FSM state enum (IDLE, XFER, RESP).
  - Length constants LEN_B=2'b00, LEN_H=2'b01, LEN_W=2'b10.
  - Function len_to_bytes (returns 1/2/4).
  - Function misaligned(len, addr[1:0]); it also flags len=11.
- **Sub-module rr_arbiter2:**
  - Combinational 2-way round-robin arbiter.
  - Holds a registered last-grant bit updated on a grant strobe.
  - Outputs a one-hot grant.
- The top level instantiates rr_arbiter2 and contains the FSM, byte counter, latches and rdata assembly.

## Test plan

- **Word fetch:** i_req, i_addr=0x10, RAM bytes 0x10..0x13 = 11,22,33,44.
  - i_ack exactly 5 cycles after accept, i_rdata=0x44332211, i_err=0.
  - mem_addr sequence is 0x10,0x11,0x12,0x13.
- **Half store then byte load:**
  - d_rw=1, d_len=01, d_addr=0x20, d_wdata=0xA5A5BEEF → bytes 0x20=EF, 0x21=BE written, 0x22 untouched.
  - Byte load at 0x21 → d_rdata=0x000000BE.
- **Alignment:**
  - Word at 0x22 → d_ack at k+1, d_err=1, mem_rw never high.
  - d_len=11 at 0x0 → same result.
- **Contention:**
  - i_req and d_req both asserted continuously, starting right after reset.
  - Grants alternate D, I, D, I.
  - No cycle has both acks high.
- **Range exception:** word store at 0x800 (RAM_WIDTH=10).
  - mem_exception on byte 0 → d_err=1 at ack.
  - mem_rw=0 throughout.
- **Reset mid-transfer:** assert rst during XFER byte 2 of a word read.
  - Next cycle: all outputs 0, no ack, state IDLE.
  - A fresh request then completes normally.
